// File: rtl/down_counter4bit_pkg.sv
// Shared constants for the 4-bit down counter: widths and FSM state encodings.
package down_counter4bit_pkg;

    localparam int CNT_W = 4;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_RUN  = 2'b01,
        S_DONE = 2'b10
    } state_t;

endpackage

// File: rtl/down_counter4bit_decrementer.sv
// Ripple decrementer: a-1 computed as a + 4'b1111; borrow is the inverted carry-out.
module decrementer4bit
    import down_counter4bit_pkg::*;
(
    input  logic [CNT_W-1:0] a,
    output logic [CNT_W-1:0] diff,
    output logic             borrow
);

    logic [CNT_W:0] carry;

    assign carry[0] = 1'b0;

    for (genvar i = 0; i < CNT_W; i++) begin : g_stage
        full_adder u_fa (
            .a   (a[i]),
            .b   (1'b1),
            .cin (carry[i]),
            .sum (diff[i]),
            .cout(carry[i+1])
        );
    end

    // Only a==0 fails to carry out of a + 4'b1111.
    assign borrow = ~carry[CNT_W];

endmodule

// File: rtl/full_adder.sv
// Gate-level full adder built from two half adders and an OR gate.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic s1;
    logic c1;
    logic c2;

    half_adder u_ha0 (.a(a),  .b(b),   .s(s1),  .c(c1));
    half_adder u_ha1 (.a(s1), .b(cin), .s(sum), .c(c2));

    assign cout = c1 | c2;

endmodule

// File: rtl/half_adder.sv
// Gate-level half adder from the arithmetic lab library.
module half_adder (
    input  logic a,
    input  logic b,
    output logic s,
    output logic c
);

    assign s = a ^ b;
    assign c = a & b;

endmodule

// File: rtl/down_counter4bit.sv
// Loadable 4-bit countdown timer with IDLE/RUN/DONE control and optional auto-reload.
module down_counter4bit
    import down_counter4bit_pkg::*;
#(
    parameter bit AUTO_RELOAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             zero,
    output logic             busy,
    output logic             done
);

    state_t           state;
    state_t           nxt_state;
    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] nxt_count;
    logic [CNT_W-1:0] nxt_reload;
    logic [CNT_W-1:0] dec_diff;
    logic             dec_borrow;

    decrementer4bit u_dec (
        .a     (count),
        .diff  (dec_diff),
        .borrow(dec_borrow)
    );

    assign zero = dec_borrow;

    always_comb begin
        nxt_state  = state;
        nxt_count  = count;
        nxt_reload = reload;
        if (load) begin
            nxt_count  = load_val;
            nxt_reload = load_val;
            nxt_state  = (load_val != '0) ? S_RUN : S_DONE;
        end else begin
            case (state)
                S_IDLE: nxt_state = S_IDLE;
                S_RUN: begin
                    // Never decrement from zero; a zero count just finishes.
                    if (dec_borrow) begin
                        nxt_state = S_DONE;
                    end else if (en) begin
                        nxt_count = dec_diff;
                        if (dec_diff == '0) nxt_state = S_DONE;
                    end
                end
                S_DONE: begin
                    if (AUTO_RELOAD) begin
                        nxt_count = reload;
                        nxt_state = (reload != '0) ? S_RUN : S_DONE;
                    end else begin
                        nxt_state = S_IDLE;
                    end
                end
                default: nxt_state = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            count  <= '0;
            reload <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt_state;
            count  <= nxt_count;
            reload <= nxt_reload;
            busy   <= (nxt_state == S_RUN);
            done   <= (nxt_state == S_DONE);
        end
    end

endmodule

// File: tb/tb_down_counter4bit.sv
// Directed bench for the down counter (both reload modes) and its decrementer.
module tb_down_counter4bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       load0, en0, load1, en1;
    logic [3:0] lv0, lv1;
    logic [3:0] count0, count1;
    logic       zero0, busy0, done0, zero1, busy1, done1;
    logic [3:0] dec_a, dec_diff;
    logic       dec_borrow;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    down_counter4bit #(.AUTO_RELOAD(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n), .load(load0), .load_val(lv0), .en(en0),
        .count(count0), .zero(zero0), .busy(busy0), .done(done0)
    );

    down_counter4bit #(.AUTO_RELOAD(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n), .load(load1), .load_val(lv1), .en(en1),
        .count(count1), .zero(zero1), .busy(busy1), .done(done1)
    );

    decrementer4bit u_dec (.a(dec_a), .diff(dec_diff), .borrow(dec_borrow));

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk0(input string tag, input logic [3:0] c, input logic b, input logic d);
        check({tag, "_count"}, 8'(count0), 8'(c));
        check({tag, "_busy"},  8'(busy0),  8'(b));
        check({tag, "_done"},  8'(done0),  8'(d));
    endtask

    task automatic chk1(input string tag, input logic [3:0] c, input logic b, input logic d);
        check({tag, "_count"}, 8'(count1), 8'(c));
        check({tag, "_busy"},  8'(busy1),  8'(b));
        check({tag, "_done"},  8'(done1),  8'(d));
    endtask

    initial begin
        logic [3:0] exp_cnt [5];
        logic       en_seq  [5];
        exp_cnt = '{4'd2, 4'd2, 4'd2, 4'd1, 4'd0};
        en_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

        rst_n = 1'b0;
        load0 = 1'b0; en0 = 1'b0; lv0 = 4'd0;
        load1 = 1'b0; en1 = 1'b0; lv1 = 4'd0;
        dec_a = 4'd0;
        #1;
        chk0("por", 4'd0, 1'b0, 1'b0);
        check("por_zero", 8'(zero0), 8'd1);
        step();
        rst_n = 1'b1;

        // Decrementer exhaustive
        for (int a = 0; a < 16; a++) begin
            dec_a = 4'(a);
            #1;
            check("dec_diff",   8'(dec_diff),   8'((a + 15) % 16));
            check("dec_borrow", 8'(dec_borrow), 8'(a == 0));
        end

        // Basic countdown from 5, then IDLE ignoring en
        load0 = 1'b1; lv0 = 4'd5; en0 = 1'b1;
        step();
        load0 = 1'b0;
        chk0("basic5", 4'd5, 1'b1, 1'b0);
        check("basic5_zero", 8'(zero0), 8'd0);
        step(); chk0("basic4", 4'd4, 1'b1, 1'b0);
        step(); chk0("basic3", 4'd3, 1'b1, 1'b0);
        step(); chk0("basic2", 4'd2, 1'b1, 1'b0);
        step(); chk0("basic1", 4'd1, 1'b1, 1'b0);
        step(); chk0("basic0", 4'd0, 1'b0, 1'b1);
        check("basic0_zero", 8'(zero0), 8'd1);
        step(); chk0("idle_a", 4'd0, 1'b0, 1'b0);
        step(); chk0("idle_b", 4'd0, 1'b0, 1'b0);

        // Enable gating
        load0 = 1'b1; lv0 = 4'd3; en0 = 1'b0;
        step();
        load0 = 1'b0;
        chk0("gate3", 4'd3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            en0 = en_seq[i];
            step();
            chk0("gate", exp_cnt[i], (i < 4), (i == 4));
        end
        en0 = 1'b0;
        step(); chk0("gate_idle", 4'd0, 1'b0, 1'b0);

        // Load priority over en mid-count, then zero load
        load0 = 1'b1; lv0 = 4'd3; en0 = 1'b1;
        step();
        load0 = 1'b0;
        step(); chk0("prio_pre", 4'd2, 1'b1, 1'b0);
        load0 = 1'b1; lv0 = 4'd7;
        step(); chk0("prio_load7", 4'd7, 1'b1, 1'b0);
        lv0 = 4'd0;
        step(); chk0("load0", 4'd0, 1'b0, 1'b1);
        load0 = 1'b0;
        step(); chk0("load0_idle", 4'd0, 1'b0, 1'b0);

        // Asynchronous reset mid-count at 9
        load0 = 1'b1; lv0 = 4'd9; en0 = 1'b0;
        step();
        load0 = 1'b0;
        chk0("pre_rst", 4'd9, 1'b1, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk0("async_rst", 4'd0, 1'b0, 1'b0);
        check("async_rst_zero", 8'(zero0), 8'd1);
        #1 rst_n = 1'b1;

        // Auto-reload: 2,1,0,2,1,0
        load1 = 1'b1; lv1 = 4'd2; en1 = 1'b1;
        step();
        load1 = 1'b0;
        chk1("ar2a", 4'd2, 1'b1, 1'b0);
        step(); chk1("ar1a", 4'd1, 1'b1, 1'b0);
        step(); chk1("ar0a", 4'd0, 1'b0, 1'b1);
        step(); chk1("ar2b", 4'd2, 1'b1, 1'b0);
        step(); chk1("ar1b", 4'd1, 1'b1, 1'b0);
        step(); chk1("ar0b", 4'd0, 1'b0, 1'b1);
        // Load during DONE beats auto-reload
        load1 = 1'b1; lv1 = 4'd4;
        step(); chk1("ar_loaddone", 4'd4, 1'b1, 1'b0);
        lv1 = 4'd0;
        step(); chk1("ar_zero_a", 4'd0, 1'b0, 1'b1);
        load1 = 1'b0;
        step(); chk1("ar_zero_b", 4'd0, 1'b0, 1'b1);
        step(); chk1("ar_zero_c", 4'd0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
